// File: rtl/fifo_arb_pkg.sv
// Purpose: shared defaults, FSM state type and queue-index helpers for the FIFO round-robin arbiter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fifo_arb_pkg;

  localparam int NQ_DEF    = 4;
  localparam int QWID_DEF  = 2;
  localparam int WIDTH_DEF = 8;
  localparam int BURST_DEF = 4;

  // IDLE: no queue holds the grant; OWN: own_id keeps the grant for a burst
  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  typedef logic [QWID_DEF-1:0] qidx_t;

  // Next queue index in round-robin order, wrapping n-1 back to 0
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Purpose: rotating-priority encoder, returns first set request at or after ptr (mod NQ).
// Latency: purely combinational.
// Backpressure: none; gnt_vld is low when no request is set.
module rr_pick #(
  parameter int NQ   = 4,
  parameter int QWID = 2
) (
  input  logic [NQ-1:0]   req,
  input  logic [QWID-1:0] ptr,
  output logic [QWID-1:0] gnt_id,
  output logic            gnt_vld
);

  int idx;

  // Scan offsets from farthest to nearest so the nearest request to ptr wins last
  always_comb begin
    gnt_id  = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = NQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NQ;
      if (req[idx]) begin
        gnt_id  = QWID'(idx);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Purpose: round-robin drain of NQ upstream FIFOs into one downstream FIFO; ARB_BURST_EN enables burst ownership.
// Latency: zero; pop/push/data/grant are combinational from registered state and current flags.
// Backpressure: dn_full blocks every pop; an owned burst is held (not released) while stalled.
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NQ    = NQ_DEF,
  parameter int QWID  = QWID_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int BURST = BURST_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NQ-1:0]       q_empty,
  input  logic [NQ*WIDTH-1:0] q_data,
  output logic [NQ-1:0]       q_pop,
  input  logic                dn_full,
  output logic                dn_push,
  output logic [WIDTH-1:0]    dn_data,
  output logic [QWID-1:0]     grant_id,
  output logic [15:0]         xfer_cnt
);

  function automatic logic [QWID-1:0] inc_idx(input logic [QWID-1:0] i);
    return QWID'(wrap_inc(int'(i), NQ));
  endfunction

  arb_state_t      state_q, state_d;
  logic [QWID-1:0] rr_ptr_q, rr_ptr_d;
  logic [QWID-1:0] pick_ptr, pick_id, win_id;
  logic            pick_vld, xfer;
  logic [15:0]     xfer_cnt_q;

`ifdef ARB_BURST_EN
  localparam int BCW = $clog2(BURST + 1);
  logic [QWID-1:0] own_id_q, own_id_d;
  logic [BCW-1:0]  burst_cnt_q, burst_cnt_d;
  logic            owner_ok;

  // When the owner has gone empty, arbitration restarts just past it in the same cycle
  always_comb begin
    pick_ptr = (state_q == OWN) ? inc_idx(own_id_q) : rr_ptr_q;
  end
`else
  // Single-grant mode always scans from the round-robin pointer
  always_comb begin
    pick_ptr = rr_ptr_q;
  end
`endif

  rr_pick #(
    .NQ   (NQ),
    .QWID (QWID)
  ) u_pick (
    .req     (~q_empty),
    .ptr     (pick_ptr),
    .gnt_id  (pick_id),
    .gnt_vld (pick_vld)
  );

`ifdef ARB_BURST_EN
  // Burst FSM: hold the owner up to BURST pops, release early when it runs dry
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    own_id_d    = own_id_q;
    burst_cnt_d = burst_cnt_q;
    win_id      = pick_id;
    xfer        = 1'b0;
    owner_ok    = !q_empty[own_id_q];
    if (state_q == OWN && owner_ok) begin
      win_id = own_id_q;
      xfer   = !dn_full && !rst;
      if (xfer) begin
        if (int'(burst_cnt_q) + 1 >= BURST) begin
          state_d     = IDLE;
          rr_ptr_d    = inc_idx(own_id_q);
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
    end else begin
      if (state_q == OWN) begin
        // owner empty: drop ownership and arbitrate from the slot after it
        state_d     = IDLE;
        rr_ptr_d    = pick_ptr;
        burst_cnt_d = '0;
      end
      xfer = pick_vld && !dn_full && !rst;
      if (xfer) begin
        if (BURST > 1) begin
          state_d     = OWN;
          own_id_d    = pick_id;
          burst_cnt_d = BCW'(1);
        end else begin
          rr_ptr_d = inc_idx(pick_id);
        end
      end
    end
  end
`else
  // Single-grant round robin: every transfer advances the pointer past the winner
  always_comb begin
    state_d  = IDLE;
    rr_ptr_d = rr_ptr_q;
    win_id   = pick_id;
    xfer     = 1'b0;
    case (state_q)
      IDLE: begin
        xfer = pick_vld && !dn_full && !rst;
        if (xfer) begin
          rr_ptr_d = inc_idx(pick_id);
        end
      end
      default: state_d = IDLE;
    endcase
  end
`endif

  // State registers and transfer counter with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      xfer_cnt_q  <= '0;
`ifdef ARB_BURST_EN
      own_id_q    <= '0;
      burst_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (xfer) begin
        xfer_cnt_q <= xfer_cnt_q + 16'd1;
      end
`ifdef ARB_BURST_EN
      own_id_q    <= own_id_d;
      burst_cnt_q <= burst_cnt_d;
`endif
    end
  end

  // Output strobes and data steering, all forced to zero when no transfer (including reset)
  always_comb begin
    q_pop    = '0;
    dn_push  = 1'b0;
    dn_data  = '0;
    grant_id = '0;
    if (xfer) begin
      q_pop[win_id] = 1'b1;
      dn_push       = 1'b1;
      dn_data       = q_data[int'(win_id)*WIDTH +: WIDTH];
      grant_id      = win_id;
    end
  end

  assign xfer_cnt = xfer_cnt_q;

`ifdef FORMAL
  // Safety properties of the pop/push interface
  always_comb begin
    assert ($onehot0(q_pop));
    assert ((q_pop & q_empty) == '0);
    assert (!(dn_push && dn_full));
    assert (dn_push == (|q_pop));
    assert (!dn_push || dn_data == q_data[int'(grant_id)*WIDTH +: WIDTH]);
  end
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Purpose: self-checking bench for fifo_rr_arbiter against a queue-level reference model.
// Latency: outputs sampled mid-cycle on the falling edge, model advanced on the rising edge.
// Backpressure: dn_full driven both directed and randomly.
module tb_fifo_rr_arbiter;

  localparam int NQ = 4, QWID = 2, W = 8, BURST = 4;
`ifdef ARB_BURST_EN
  localparam bit BURST_MODE = 1'b1;
`else
  localparam bit BURST_MODE = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [NQ-1:0]   q_empty;
  logic [NQ*W-1:0] q_data;
  logic [NQ-1:0]   q_pop;
  logic            dn_full;
  logic            dn_push;
  logic [W-1:0]    dn_data;
  logic [QWID-1:0] grant_id;
  logic [15:0]     xfer_cnt;

  int checks = 0;
  int failures = 0;

  // reference model: pointer, current owner (-1 none), pops given to owner, transfer count
  int m_ptr = 0, m_own = -1, m_cnt = 0;
  int n_ptr, n_own, n_cnt;
  logic [15:0] m_xfer = '0, n_xfer;
  logic [NQ-1:0]   e_pop;
  logic            e_push;
  logic [W-1:0]    e_data;
  logic [QWID-1:0] e_gid;
  logic [15:0]     e_xfer;

  always #5 clk = ~clk;

  fifo_rr_arbiter #(.NQ(NQ), .QWID(QWID), .WIDTH(W), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .q_empty(q_empty), .q_data(q_data), .q_pop(q_pop),
    .dn_full(dn_full), .dn_push(dn_push), .dn_data(dn_data),
    .grant_id(grant_id), .xfer_cnt(xfer_cnt)
  );

  function automatic void model_eval();
    int w, start;
    e_pop = '0; e_push = 1'b0; e_data = '0; e_gid = '0; e_xfer = m_xfer;
    n_ptr = m_ptr; n_own = m_own; n_cnt = m_cnt; n_xfer = m_xfer;
    if (rst) begin
      n_ptr = 0; n_own = -1; n_cnt = 0; n_xfer = '0;
      return;
    end
    w = -1;
    if (m_own >= 0 && !q_empty[m_own]) begin
      if (!dn_full) begin
        w = m_own;
        n_cnt = m_cnt + 1;
        if (n_cnt == BURST) begin
          n_own = -1; n_cnt = 0; n_ptr = (m_own + 1) % NQ;
        end
      end
    end else begin
      start = m_ptr;
      if (m_own >= 0) begin
        start = (m_own + 1) % NQ;
        n_ptr = start; n_own = -1; n_cnt = 0;
      end
      for (int k = 0; k < NQ; k++)
        if (w < 0 && !q_empty[(start + k) % NQ]) w = (start + k) % NQ;
      if (dn_full) w = -1;
      if (w >= 0) begin
        if (BURST_MODE && BURST > 1) begin
          n_own = w; n_cnt = 1;
        end else begin
          n_ptr = (w + 1) % NQ;
        end
      end
    end
    if (w >= 0) begin
      e_pop[w] = 1'b1; e_push = 1'b1; e_data = q_data[w*W +: W]; e_gid = QWID'(w);
      n_xfer = m_xfer + 16'd1;
    end
  endfunction

  task automatic settle();
    #4;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    m_ptr = n_ptr; m_own = n_own; m_cnt = n_cnt; m_xfer = n_xfer;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; q_empty = '0; dn_full = 1'b0;
    for (int c = 0; c < 2; c++) begin
      q_data = $urandom;
      settle();
      checks++;
      if ({q_pop, dn_push, dn_data, grant_id} !== '0) begin
        failures++;
        $display("FAIL reset_gate cyc=%0d: got pop=%b push=%b data=%h gid=%0d, want all zero",
                 c, q_pop, dn_push, dn_data, grant_id);
      end
      advance();
    end
    rst = 1'b0;
    settle();
    checks++;
    if (xfer_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_cnt: got xfer_cnt=%0d, want 0", xfer_cnt);
    end
    checks++;
    if ({q_pop, dn_push, grant_id} !== {4'b0001, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL reset_first_grant: got pop=%b push=%b gid=%0d, want pop=0001 push=1 gid=0",
               q_pop, dn_push, grant_id);
    end
    advance();
  endtask

  task automatic test_round_robin();
    rst = 1'b1; settle(); advance();
    rst = 1'b0; q_empty = '0; dn_full = 1'b0;
    for (int i = 0; i < 8; i++) begin
      q_data = $urandom;
      settle();
      checks++;
      if ({q_pop, dn_push, dn_data, grant_id, xfer_cnt} !== {e_pop, e_push, e_data, e_gid, e_xfer}) begin
        failures++;
        $display("FAIL rr_seq cyc=%0d: got pop=%b push=%b data=%h gid=%0d cnt=%0d, want pop=%b push=%b data=%h gid=%0d cnt=%0d",
                 i, q_pop, dn_push, dn_data, grant_id, xfer_cnt, e_pop, e_push, e_data, e_gid, e_xfer);
      end
`ifndef ARB_BURST_EN
      checks++;
      if (grant_id !== QWID'(i % NQ)) begin
        failures++;
        $display("FAIL rr_order cyc=%0d: got gid=%0d, want %0d", i, grant_id, i % NQ);
      end
`endif
      advance();
    end
    settle();
    checks++;
    if (xfer_cnt !== 16'd8) begin
      failures++;
      $display("FAIL rr_count: got xfer_cnt=%0d, want 8", xfer_cnt);
    end
    advance();
  endtask

  task automatic test_single_queue();
    q_empty = 4'b1011; dn_full = 1'b0;
    for (int i = 0; i < 6; i++) begin
      q_data = $urandom;
      settle();
      checks++;
      if (q_pop !== 4'b0100 || dn_data !== q_data[23:16] || xfer_cnt !== e_xfer) begin
        failures++;
        $display("FAIL single_q cyc=%0d: got pop=%b data=%h cnt=%0d, want pop=0100 data=%h cnt=%0d",
                 i, q_pop, dn_data, xfer_cnt, q_data[23:16], e_xfer);
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    rst = 1'b1; settle(); advance();
    rst = 1'b0; q_empty = 4'b1100; dn_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q_data = $urandom;
      settle();
      checks++;
      if (q_pop !== 4'b0000 || dn_push !== 1'b0) begin
        failures++;
        $display("FAIL stall cyc=%0d: got pop=%b push=%b, want pop=0000 push=0", i, q_pop, dn_push);
      end
      advance();
    end
    dn_full = 1'b0;
    settle();
    checks++;
    if (q_pop !== 4'b0001 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL stall_resume: got pop=%b gid=%0d, want pop=0001 gid=0", q_pop, grant_id);
    end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      q_data  = $urandom;
      for (int q = 0; q < NQ; q++) q_empty[q] = ($urandom_range(0, 9) < 4);
      dn_full = ($urandom_range(0, 3) == 0);
      rst     = ($urandom_range(0, 59) == 0);
      settle();
      checks++;
      if ({q_pop, dn_push, dn_data, grant_id, xfer_cnt} !== {e_pop, e_push, e_data, e_gid, e_xfer}) begin
        failures++;
        $display("FAIL random cyc=%0d: got pop=%b push=%b data=%h gid=%0d cnt=%0d, want pop=%b push=%b data=%h gid=%0d cnt=%0d",
                 i, q_pop, dn_push, dn_data, grant_id, xfer_cnt, e_pop, e_push, e_data, e_gid, e_xfer);
      end
      advance();
    end
    rst = 1'b0;
  endtask

`ifdef ARB_BURST_EN
  task automatic test_burst();
    int exp_g[10] = '{0, 0, -1, -1, 0, 0, 1, 1, 1, 1};
    rst = 1'b1; settle(); advance();
    rst = 1'b0; q_empty = '0;
    for (int i = 0; i < 10; i++) begin
      q_data  = $urandom;
      dn_full = (i == 2 || i == 3);
      settle();
      checks++;
      if (dn_push !== (exp_g[i] >= 0) || (exp_g[i] >= 0 && grant_id !== QWID'(exp_g[i]))
          || {q_pop, dn_data, xfer_cnt} !== {e_pop, e_data, e_xfer}) begin
        failures++;
        $display("FAIL burst cyc=%0d: got push=%b gid=%0d pop=%b cnt=%0d, want grant %0d pop=%b cnt=%0d",
                 i, dn_push, grant_id, q_pop, xfer_cnt, exp_g[i], e_pop, e_xfer);
      end
      advance();
    end
    dn_full = 1'b0;
  endtask

  task automatic test_release();
    rst = 1'b1; settle(); advance();
    rst = 1'b0; q_empty = '0; dn_full = 1'b0;
    for (int i = 0; i < 6; i++) begin
      q_data  = $urandom;
      q_empty = (i >= 2 && i <= 4) ? 4'b0001 : 4'b0000;
      rst     = (i == 4);
      settle();
      checks++;
      if ({q_pop, dn_push, dn_data, grant_id} !== {e_pop, e_push, e_data, e_gid}
          || (i == 2 && grant_id !== 2'd1) || (i == 4 && dn_push !== 1'b0)
          || (i == 5 && grant_id !== 2'd0)) begin
        failures++;
        $display("FAIL release cyc=%0d: got pop=%b push=%b gid=%0d, want pop=%b push=%b gid=%0d",
                 i, q_pop, dn_push, grant_id, e_pop, e_push, e_gid);
      end
      advance();
    end
    rst = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; q_empty = '1; q_data = '0; dn_full = 1'b0;
    #1;
    test_reset();
    test_round_robin();
    test_single_queue();
    test_backpressure();
`ifdef ARB_BURST_EN
    test_burst();
    test_release();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
